// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode boundary bundle: fetch-side handshake, decode-side head view, flush.
// The FD_QUEUE_STATS_EN macro adds the occupancy/stall statistics signals.
interface fetch_decode_queue_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                  FlushD;
  logic                  validF;
  logic                  readyF;
  logic [DATA_WIDTH-1:0] instrF;
  logic [DATA_WIDTH-1:0] pcF;
  logic [DATA_WIDTH-1:0] PCPlus4F;
  logic                  validD;
  logic                  readyD;
  logic [DATA_WIDTH-1:0] instrD;
  logic [DATA_WIDTH-1:0] pcD;
  logic [DATA_WIDTH-1:0] PCPlus4D;
  logic [CW-1:0]         count;
`ifdef FD_QUEUE_STATS_EN
  logic [CW-1:0]         peak_occ;
  logic [31:0]           full_stall_cnt;

  modport master (
    output FlushD, validF, instrF, pcF, PCPlus4F, readyD,
    input  readyF, validD, instrD, pcD, PCPlus4D, count, peak_occ, full_stall_cnt
  );
  modport slave (
    input  FlushD, validF, instrF, pcF, PCPlus4F, readyD,
    output readyF, validD, instrD, pcD, PCPlus4D, count, peak_occ, full_stall_cnt
  );
`else
  modport master (
    output FlushD, validF, instrF, pcF, PCPlus4F, readyD,
    input  readyF, validD, instrD, pcD, PCPlus4D, count
  );
  modport slave (
    input  FlushD, validF, instrF, pcF, PCPlus4F, readyD,
    output readyF, validD, instrD, pcD, PCPlus4D, count
  );
`endif
endinterface

// File: rtl/fetch_decode_queue.sv
// DEPTH-entry IF/ID FIFO carrying {instr, pc, PC+4}; empty head reads as a NOP.
// Optional FD_QUEUE_STATS_EN adds peak occupancy and full-stall counters.
module fetch_decode_queue #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_decode_queue_if.slave q
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  // Flush wins over both sides; readyF comes from occupancy only.
  assign push  = q.validF && !full && !q.FlushD;
  assign pop   = !empty && q.readyD && !q.FlushD;

  always_comb begin
    cnt_nxt = cnt;
    if (q.FlushD)
      cnt_nxt = '0;
    else if (push && !pop)
      cnt_nxt = cnt + CW'(1);
    else if (!push && pop)
      cnt_nxt = cnt - CW'(1);
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (q.FlushD) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Entry storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_t'{q.instrF, q.pcF, q.PCPlus4F};
  end

  assign head       = mem[rd_ptr];
  assign q.readyF   = !full;
  assign q.validD   = !empty;
  assign q.count    = cnt;
  assign q.instrD   = empty ? NOP_INSTR : head.instr;
  assign q.pcD      = empty ? '0 : head.pc;
  assign q.PCPlus4D = empty ? '0 : head.pc_plus4;

`ifdef FD_QUEUE_STATS_EN
  logic [CW-1:0] peak_q;
  logic [31:0]   stall_q;

  // Statistics survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q  <= '0;
      stall_q <= '0;
    end else begin
      if (cnt_nxt > peak_q) peak_q <= cnt_nxt;
      if (q.validF && full && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
    end
  end

  assign q.peak_occ       = peak_q;
  assign q.full_stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue: queue-based reference model plus literal checks.
// Build with FD_QUEUE_STATS_EN to also check the statistics outputs.
module tb_fetch_decode_queue;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ent_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  fetch_decode_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  fetch_decode_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO driven by the handshake rules.
  ent_t        mq[$];
  int          m_peak;
  logic [31:0] m_stall;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_peak  = 0;
      m_stall = 0;
    end else begin
      bit can_take;
      bit has_head;
      can_take = (mq.size() < DEPTH);
      has_head = (mq.size() != 0);
      if (bus.validF && !can_take && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (bus.FlushD) mq.delete();
      else begin
        ent_t e;
        e.instr = bus.instrF;
        e.pc    = bus.pcF;
        e.pc4   = bus.PCPlus4F;
        if (has_head && bus.readyD) void'(mq.pop_front());
        if (bus.validF && can_take) mq.push_back(e);
      end
      if (mq.size() > m_peak) m_peak = mq.size();
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    int n;
    n = mq.size();
    chk("cyc_validD", 64'(bus.validD), 64'(n != 0));
    chk("cyc_readyF", 64'(bus.readyF), 64'(n < DEPTH));
    chk("cyc_count",  64'(bus.count),  64'(n));
    chk("cyc_instrD", 64'(bus.instrD), (n != 0) ? 64'(mq[0].instr) : 64'(NOP));
    chk("cyc_pcD",    64'(bus.pcD),    (n != 0) ? 64'(mq[0].pc)    : 64'd0);
    chk("cyc_pc4D",   64'(bus.PCPlus4D), (n != 0) ? 64'(mq[0].pc4) : 64'd0);
`ifdef FD_QUEUE_STATS_EN
    chk("cyc_peak",  64'(bus.peak_occ),       64'(m_peak));
    chk("cyc_stall", 64'(bus.full_stall_cnt), 64'(m_stall));
`endif
  end

  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rd, input logic fl);
    bus.validF   = v;
    bus.instrF   = ins;
    bus.pcF      = pc;
    bus.PCPlus4F = pc + 32'd4;
    bus.readyD   = rd;
    bus.FlushD   = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.validF = 1'b0; bus.instrF = '0; bus.pcF = '0; bus.PCPlus4F = '0;
    bus.readyD = 1'b0; bus.FlushD = 1'b0;
    #12 rst_n = 1'b1;
    @(negedge clk);

    // 1: reset / idle
    chk("rst_validD", 64'(bus.validD), 64'd0);
    chk("rst_instrD", 64'(bus.instrD), 64'h13);
    chk("rst_pcD",    64'(bus.pcD),    64'd0);
    chk("rst_readyF", 64'(bus.readyF), 64'd1);
    chk("rst_count",  64'(bus.count),  64'd0);
`ifdef FD_QUEUE_STATS_EN
    chk("rst_peak",  64'(bus.peak_occ),       64'd0);
    chk("rst_stall", 64'(bus.full_stall_cnt), 64'd0);
`endif

    // 2: three pushes then three pops in order
    cycle(1, 32'h0050_0093, 32'h0, 0, 0);
    cycle(1, 32'h00A0_0113, 32'h4, 0, 0);
    cycle(1, 32'h0020_81B3, 32'h8, 0, 0);
    chk("s2_count3", 64'(bus.count), 64'd3);
    chk("s2_i0", 64'(bus.instrD), 64'h0050_0093);
    chk("s2_p0", 64'(bus.pcD), 64'h0);
    chk("s2_q0", 64'(bus.PCPlus4D), 64'h4);
    cycle(0, 32'h0, 32'h0, 1, 0);
    chk("s2_i1", 64'(bus.instrD), 64'h00A0_0113);
    chk("s2_p1", 64'(bus.pcD), 64'h4);
    chk("s2_q1", 64'(bus.PCPlus4D), 64'h8);
    cycle(0, 32'h0, 32'h0, 1, 0);
    chk("s2_i2", 64'(bus.instrD), 64'h0020_81B3);
    chk("s2_p2", 64'(bus.pcD), 64'h8);
    chk("s2_q2", 64'(bus.PCPlus4D), 64'hC);
    cycle(0, 32'h0, 32'h0, 1, 0);
    chk("s2_empty", 64'(bus.validD), 64'd0);

    // 3: fill, refused fifth, then accepted after one pop
    for (int i = 0; i < 4; i++) cycle(1, 32'h1000 + 32'(i), 32'(4 * i), 0, 0);
    chk("s3_full_readyF", 64'(bus.readyF), 64'd0);
    chk("s3_full_count",  64'(bus.count),  64'd4);
    cycle(1, 32'h2010, 32'h10, 1, 0);
    chk("s3_pop_count",  64'(bus.count),  64'd3);
    chk("s3_pop_readyF", 64'(bus.readyF), 64'd1);
    chk("s3_pop_head",   64'(bus.pcD),    64'h4);
    cycle(1, 32'h2010, 32'h10, 0, 0);
    chk("s3_refill", 64'(bus.count), 64'd4);
`ifdef FD_QUEUE_STATS_EN
    chk("s3_peak",  64'(bus.peak_occ),       64'd4);
    chk("s3_stall", 64'(bus.full_stall_cnt), 64'd1);
`endif
    for (int i = 0; i < 4; i++) cycle(0, 32'h0, 32'h0, 1, 0);
    chk("s3_drained", 64'(bus.count), 64'd0);

    // 4: streaming push+pop, pointers wrap
    cycle(1, 32'h3000, 32'h100, 1, 0);
    for (int i = 0; i < 10; i++) begin
      chk("s4_pcD",   64'(bus.pcD),   64'(32'h100 + 32'(4 * i)));
      chk("s4_count", 64'(bus.count), 64'd1);
      cycle(1, 32'h3001 + 32'(i), 32'h104 + 32'(4 * i), 1, 0);
    end
    cycle(0, 32'h0, 32'h0, 1, 0);
    chk("s4_drained", 64'(bus.validD), 64'd0);

    // 5: flush beats simultaneous push and pop
    for (int i = 0; i < 3; i++) cycle(1, 32'h4000 + 32'(i), 32'h200 + 32'(4 * i), 0, 0);
    chk("s5_count3", 64'(bus.count), 64'd3);
    cycle(1, 32'h4FFF, 32'h300, 1, 1);
    chk("s5_count",  64'(bus.count),  64'd0);
    chk("s5_validD", 64'(bus.validD), 64'd0);
    chk("s5_instrD", 64'(bus.instrD), 64'h13);
    chk("s5_readyF", 64'(bus.readyF), 64'd1);
    cycle(0, 32'h0, 32'h0, 0, 0);
    chk("s5_absent", 64'(bus.count), 64'd0);

    // 6: asynchronous reset between edges
    cycle(1, 32'h5000, 32'h400, 0, 0);
    cycle(1, 32'h5001, 32'h404, 0, 0);
    chk("s6_count2", 64'(bus.count), 64'd2);
    bus.validF = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_validD", 64'(bus.validD), 64'd0);
    chk("s6_count",  64'(bus.count),  64'd0);
    chk("s6_instrD", 64'(bus.instrD), 64'h13);
`ifdef FD_QUEUE_STATS_EN
    chk("s6_peak",  64'(bus.peak_occ),       64'd0);
    chk("s6_stall", 64'(bus.full_stall_cnt), 64'd0);
`endif
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    cycle(0, 32'h0, 32'h0, 1, 0);
    chk("s6_after", 64'(bus.validD), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
